// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: frame command codes,
// error reply code, FSM state encoding and ALU operand RF locations.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] ERR_CODE    = 8'hEE;

  localparam int unsigned ALU_OPA_ADDR = 0;
  localparam int unsigned ALU_OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUN,
    ALU_WAIT,
    TX_LO,
    TX_HI,
    TX_RD,
    TX_ERR
  } state_t;

  // States that push a word into the TX FIFO.
  function automatic logic is_tx_state(input state_t s);
    return s inside {TX_LO, TX_HI, TX_RD, TX_ERR};
  endfunction

  // States in which the inter-word timeout runs.
  function automatic logic is_timed_state(input state_t s);
    return (s != IDLE) && !is_tx_state(s);
  endfunction

  // First state of a frame for a given command byte; unknown codes go to TX_ERR.
  function automatic state_t decode_cmd(input logic [7:0] code);
    case (code)
      CMD_WR:      return WR_ADDR;
      CMD_RD:      return RD_ADDR;
      CMD_ALU_OP:  return OPA;
      CMD_ALU_NOP: return FUN;
      default:     return TX_ERR;
    endcase
  endfunction

endpackage

// File: rtl/sys_ctrl_gen2_if.sv
// Bundle of the UART RX/TX, register-file and ALU signals seen by the
// controller. master = controller side, slave = surrounding system.
interface sys_ctrl_gen2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   Rd_Data;
  logic                    Rd_Data_Valid;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_VALID;
  logic                    FIFO_FULL;

  logic                    WrEn;
  logic                    RdEn;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   WrData;
  logic                    ALU_EN;
  logic [3:0]              ALU_FUN;
  logic                    CLK_EN;
  logic                    clk_div_en;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, Rd_Data, Rd_Data_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    output WrEn, RdEn, address, WrData, ALU_EN, ALU_FUN, CLK_EN, clk_div_en,
           TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, Rd_Data, Rd_Data_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    input  WrEn, RdEn, address, WrData, ALU_EN, ALU_FUN, CLK_EN, clk_div_en,
           TX_P_DATA, TX_D_VLD, CMD_ERR
  );

endinterface

// File: rtl/sys_ctrl_timer.sv
// Inter-word watchdog. Counts while run is high, restarts on clear or when
// not running, and flags expiry once the count sits at TIMEOUT_CYCLES-1.
module sys_ctrl_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Saturating up-count while running; any activity restarts from zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/sys_ctrl_gen2.sv
// Frame-decoding system controller: turns UART command frames into RF
// writes/reads and ALU runs, and returns results through the TX FIFO.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for a command byte
// WR_ADDR  | 0xAA seen, waiting for RF address
// WR_DATA  | waiting for RF write data
// RD_ADDR  | 0xBB seen, waiting for RF address
// RD_WAIT  | RF read issued, waiting for Rd_Data_Valid
// OPA      | 0xCC seen, waiting for operand A (RF addr 0)
// OPB      | waiting for operand B (RF addr 1)
// FUN      | waiting for ALU function word
// ALU_WAIT | ALU started, waiting for OUT_VALID
// TX_LO    | sending low half of ALU result
// TX_HI    | sending high half of ALU result
// TX_RD    | sending RF read data
// TX_ERR   | sending error code
module sys_ctrl_gen2
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             CLK,
  input logic             RST,
  sys_ctrl_gen2_if.master bus
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic [2*DATA_WIDTH-1:0] alu_q, alu_d;

  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  clk_en_q, clk_en_d;
  logic                  clk_div_en_q;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  cmd_err_q, cmd_err_d;

  logic                  tmr_clear, tmr_run, tmr_expired, take_timeout;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  cmd_upper_zero, addr_ok;

  assign rx_word        = bus.RX_P_DATA;
  assign cmd_upper_zero = (rx_word >> 8) == '0;
  assign addr_ok        = (rx_word >> ADDR_WIDTH) == '0;

  assign tmr_run   = is_timed_state(state_q);
  assign tmr_clear = bus.RX_D_VLD || bus.Rd_Data_Valid || bus.OUT_VALID || (state_d != state_q);

  sys_ctrl_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  // Next-state and next-output decode; data events always take priority over timeout.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    alu_en_d     = 1'b0;
    tx_vld_d     = 1'b0;
    cmd_err_d    = 1'b0;
    clk_en_d     = 1'b0;
    address_d    = address_q;
    wr_data_d    = wr_data_q;
    alu_fun_d    = alu_fun_q;
    tx_data_d    = tx_data_q;
    take_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          state_d   = cmd_upper_zero ? decode_cmd(rx_word[7:0]) : TX_ERR;
          cmd_err_d = (state_d == TX_ERR);
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = rx_word[ADDR_WIDTH-1:0];
            state_d = WR_DATA;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = TX_ERR;
          end
        end else if (tmr_expired) begin
          take_timeout = 1'b1;
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = rx_word;
          state_d   = IDLE;
        end else if (tmr_expired) begin
          take_timeout = 1'b1;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          if (addr_ok) begin
            rd_en_d   = 1'b1;
            address_d = rx_word[ADDR_WIDTH-1:0];
            state_d   = RD_WAIT;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = TX_ERR;
          end
        end else if (tmr_expired) begin
          take_timeout = 1'b1;
        end
      end
      RD_WAIT: begin
        if (bus.Rd_Data_Valid) begin
          rd_d    = bus.Rd_Data;
          state_d = TX_RD;
        end else if (tmr_expired) begin
          take_timeout = 1'b1;
        end
      end
      OPA, OPB: begin
        if (bus.RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = (state_q == OPA) ? ADDR_WIDTH'(ALU_OPA_ADDR) : ADDR_WIDTH'(ALU_OPB_ADDR);
          wr_data_d = rx_word;
          state_d   = (state_q == OPA) ? OPB : FUN;
        end else if (tmr_expired) begin
          take_timeout = 1'b1;
        end
      end
      FUN: begin
        if (bus.RX_D_VLD) begin
          alu_fun_d = rx_word[3:0];
          alu_en_d  = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end else if (tmr_expired) begin
          take_timeout = 1'b1;
        end
      end
      ALU_WAIT: begin
        // Gate stays open through the cycle after OUT_VALID.
        clk_en_d = 1'b1;
        if (bus.OUT_VALID) begin
          alu_d   = bus.ALU_OUT;
          state_d = TX_LO;
        end else if (tmr_expired) begin
          take_timeout = 1'b1;
        end
      end
      TX_LO: begin
        if (!bus.FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = alu_q[DATA_WIDTH-1:0];
          state_d   = TX_HI;
        end
      end
      TX_HI: begin
        if (!bus.FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = alu_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = IDLE;
        end
      end
      TX_RD: begin
        if (!bus.FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = rd_q;
          state_d   = IDLE;
        end
      end
      TX_ERR: begin
        if (!bus.FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = DATA_WIDTH'(ERR_CODE);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_timeout) begin
      state_d   = IDLE;
      cmd_err_d = 1'b1;
      clk_en_d  = 1'b0;
    end

    // Words arriving while a reply is being sent are dropped and flagged.
    if (is_tx_state(state_q) && bus.RX_D_VLD) begin
      cmd_err_d = 1'b1;
    end
  end

  // State, latched frame data and all outputs are registered here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rd_q         <= '0;
      alu_q        <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      address_q    <= '0;
      wr_data_q    <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      clk_en_q     <= 1'b0;
      clk_div_en_q <= 1'b0;
      tx_data_q    <= '0;
      tx_vld_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      address_q    <= address_d;
      wr_data_q    <= wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      clk_en_q     <= clk_en_d;
      clk_div_en_q <= 1'b1;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign bus.WrEn       = wr_en_q;
  assign bus.RdEn       = rd_en_q;
  assign bus.address    = address_q;
  assign bus.WrData     = wr_data_q;
  assign bus.ALU_EN     = alu_en_q;
  assign bus.ALU_FUN    = alu_fun_q;
  assign bus.CLK_EN     = clk_en_q;
  assign bus.clk_div_en = clk_div_en_q;
  assign bus.TX_P_DATA  = tx_data_q;
  assign bus.TX_D_VLD   = tx_vld_q;
  assign bus.CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Directed bench for sys_ctrl_gen2: drives command frames, plays the RF,
// ALU and TX FIFO by hand, and checks strobes, data and error handling.
module tb_sys_ctrl_gen2;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  sys_ctrl_gen2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sys_ctrl_gen2 #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Event logs, sampled on the falling edge.
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  logic [AW-1:0] rd_addr_log[$];
  logic [DW-1:0] tx_log[$];
  int            alu_en_cnt = 0;
  int            cmd_err_cnt = 0;

  int m_wr, m_rd, m_tx, m_alu, m_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.WrEn) begin
        wr_addr_log.push_back(bus.address);
        wr_data_log.push_back(bus.WrData);
      end
      if (bus.RdEn)     rd_addr_log.push_back(bus.address);
      if (bus.TX_D_VLD) tx_log.push_back(bus.TX_P_DATA);
      if (bus.ALU_EN)   alu_en_cnt++;
      if (bus.CMD_ERR)  cmd_err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    m_wr  = wr_addr_log.size();
    m_rd  = rd_addr_log.size();
    m_tx  = tx_log.size();
    m_alu = alu_en_cnt;
    m_err = cmd_err_cnt;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bus.RX_P_DATA = w;
    bus.RX_D_VLD  = 1'b1;
    tick(1);
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = '0;
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.WrEn, bus.RdEn, bus.address, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
                bus.CLK_EN, bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;

    bus.RX_P_DATA     = '0;
    bus.RX_D_VLD      = 1'b0;
    bus.Rd_Data       = '0;
    bus.Rd_Data_Valid = 1'b0;
    bus.ALU_OUT       = '0;
    bus.OUT_VALID     = 1'b0;
    bus.FIFO_FULL     = 1'b0;

    // Reset state
    tick(2);
    chk("rst_outs", outs(), 32'h0);
    chk("rst_clkdiv", 32'(bus.clk_div_en), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("clkdiv_after_rst", 32'(bus.clk_div_en), 32'h1);
    chk("outs_after_rst", outs(), 32'h0);

    // AA,05,3C: RF write
    mark();
    send_word(8'hAA);
    send_word(8'h05);
    send_word(8'h3C);
    chk("s1_wren_now", 32'(bus.WrEn), 32'h1);
    tick(3);
    chk("s1_wr_cnt", 32'(wr_addr_log.size() - m_wr), 32'd1);
    chk("s1_wr_addr", 32'(wr_addr_log[m_wr]), 32'h5);
    chk("s1_wr_data", 32'(wr_data_log[m_wr]), 32'h3C);
    chk("s1_no_tx", 32'(tx_log.size() - m_tx), 32'd0);
    chk("s1_no_err", 32'(cmd_err_cnt - m_err), 32'd0);

    // BB,05: RF read, data returned after 3 cycles
    mark();
    send_word(8'hBB);
    send_word(8'h05);
    chk("s2_rden_now", 32'(bus.RdEn), 32'h1);
    chk("s2_rd_addr", 32'(bus.address), 32'h5);
    tick(2);
    bus.Rd_Data       = 8'h3C;
    bus.Rd_Data_Valid = 1'b1;
    tick(1);
    bus.Rd_Data_Valid = 1'b0;
    bus.Rd_Data       = '0;
    tick(4);
    chk("s2_rden_cnt", 32'(rd_addr_log.size() - m_rd), 32'd1);
    chk("s2_tx_cnt", 32'(tx_log.size() - m_tx), 32'd1);
    chk("s2_tx_data", 32'(tx_log[m_tx]), 32'h3C);

    // CC,07,03,00: operand writes then ALU add, result 0x000A
    mark();
    send_word(8'hCC);
    send_word(8'h07);
    send_word(8'h03);
    send_word(8'h00);
    chk("s3_alu_en", 32'(bus.ALU_EN), 32'h1);
    chk("s3_alu_fun", 32'(bus.ALU_FUN), 32'h0);
    chk("s3_clk_en_on", 32'(bus.CLK_EN), 32'h1);
    tick(2);
    chk("s3_clk_en_wait", 32'(bus.CLK_EN), 32'h1);
    bus.ALU_OUT   = 16'h000A;
    bus.OUT_VALID = 1'b1;
    tick(1);
    bus.OUT_VALID = 1'b0;
    chk("s3_clk_en_tail", 32'(bus.CLK_EN), 32'h1);
    tick(1);
    chk("s3_clk_en_off", 32'(bus.CLK_EN), 32'h0);
    tick(3);
    chk("s3_wr_cnt", 32'(wr_addr_log.size() - m_wr), 32'd2);
    chk("s3_opa", {wr_addr_log[m_wr], wr_data_log[m_wr]}, 32'h007);
    chk("s3_opb", {wr_addr_log[m_wr+1], wr_data_log[m_wr+1]}, 32'h103);
    chk("s3_tx_cnt", 32'(tx_log.size() - m_tx), 32'd2);
    chk("s3_tx_lo", 32'(tx_log[m_tx]), 32'h0A);
    chk("s3_tx_hi", 32'(tx_log[m_tx+1]), 32'h00);
    chk("s3_alu_en_cnt", 32'(alu_en_cnt - m_alu), 32'd1);

    // Bad command byte, then out-of-range address
    mark();
    send_word(8'h55);
    chk("s4_err_cmd", 32'(bus.CMD_ERR), 32'h1);
    tick(3);
    chk("s4_tx_cnt1", 32'(tx_log.size() - m_tx), 32'd1);
    chk("s4_tx_ee1", 32'(tx_log[m_tx]), 32'hEE);
    send_word(8'hAA);
    send_word(8'h1F);
    chk("s4_err_addr", 32'(bus.CMD_ERR), 32'h1);
    tick(3);
    chk("s4_tx_cnt2", 32'(tx_log.size() - m_tx), 32'd2);
    chk("s4_tx_ee2", 32'(tx_log[m_tx+1]), 32'hEE);
    chk("s4_err_cnt", 32'(cmd_err_cnt - m_err), 32'd2);
    chk("s4_no_wr", 32'(wr_addr_log.size() - m_wr), 32'd0);

    // AA then silence: timeout
    mark();
    send_word(8'hAA);
    k = 0;
    while (k < 1200 && !bus.CMD_ERR) begin
      tick(1);
      k++;
    end
    chk("s5_timeout_seen", (k < 1200) ? 32'h1 : 32'h0, 32'h1);
    chk("s5_timeout_lat", (k >= TO - 4 && k <= TO + 4) ? 32'h1 : 32'h0, 32'h1);
    chk("s5_clk_en", 32'(bus.CLK_EN), 32'h0);
    tick(2);
    chk("s5_err_cnt", 32'(cmd_err_cnt - m_err), 32'd1);
    chk("s5_no_wr", 32'(wr_addr_log.size() - m_wr), 32'd0);
    chk("s5_no_tx", 32'(tx_log.size() - m_tx), 32'd0);
    send_word(8'hAA);
    send_word(8'h02);
    send_word(8'h11);
    tick(2);
    chk("s5_idle_wr_cnt", 32'(wr_addr_log.size() - m_wr), 32'd1);
    chk("s5_idle_wr", {wr_addr_log[m_wr], wr_data_log[m_wr]}, 32'h211);

    // DD,01 with FIFO full for 10 cycles in TX_LO; a word arriving meanwhile is dropped
    mark();
    send_word(8'hDD);
    send_word(8'h01);
    chk("s6_alu_fun", 32'(bus.ALU_FUN), 32'h1);
    tick(1);
    bus.FIFO_FULL = 1'b1;
    bus.ALU_OUT   = 16'h1234;
    bus.OUT_VALID = 1'b1;
    tick(1);
    bus.OUT_VALID = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bus.RX_P_DATA = 8'hAA;
        bus.RX_D_VLD  = 1'b1;
      end
      if (i == 5) begin
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = '0;
      end
      tick(1);
      if (bus.TX_D_VLD !== 1'b0 || bus.TX_P_DATA !== 8'hEE) bad++;
    end
    chk("s6_hold", 32'(bad), 32'd0);
    chk("s6_no_tx", 32'(tx_log.size() - m_tx), 32'd0);
    chk("s6_drop_err", 32'(cmd_err_cnt - m_err), 32'd1);
    bus.FIFO_FULL = 1'b0;
    tick(1);
    chk("s6_tx_vld_lo", 32'(bus.TX_D_VLD), 32'h1);
    chk("s6_tx_lo", 32'(bus.TX_P_DATA), 32'h34);
    tick(1);
    chk("s6_tx_vld_hi", 32'(bus.TX_D_VLD), 32'h1);
    chk("s6_tx_hi", 32'(bus.TX_P_DATA), 32'h12);
    tick(2);
    chk("s6_tx_cnt", 32'(tx_log.size() - m_tx), 32'd2);

    // Reset pulse during ALU_WAIT, then a fresh frame
    send_word(8'hDD);
    send_word(8'h02);
    chk("s7_clk_en_on", 32'(bus.CLK_EN), 32'h1);
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    chk("s7_rst_outs", outs(), 32'h0);
    chk("s7_rst_clkdiv", 32'(bus.clk_div_en), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    mark();
    send_word(8'hAA);
    send_word(8'h03);
    send_word(8'h55);
    tick(2);
    chk("s7_new_wr_cnt", 32'(wr_addr_log.size() - m_wr), 32'd1);
    chk("s7_new_wr", {wr_addr_log[m_wr], wr_data_log[m_wr]}, 32'h355);
    chk("s7_no_err", 32'(cmd_err_cnt - m_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_gen2.md
SYS_CTRL_GEN2 -- requirements
Module: sys_ctrl_gen2

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 8: RX/TX/RF word width; minimum 8.
- ADDR_WIDTH, 4: RF address width.
- TIMEOUT_CYCLES, 1024: idle cycles allowed between frame words.
REQ-002 Ports SHALL be:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  DATA_WIDTH  received UART word.
- RX_D_VLD  in  1  one-cycle strobe qualifying RX_P_DATA.
- Rd_Data  in  DATA_WIDTH  RF read data.
- Rd_Data_Valid  in  1  RF read data valid.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- OUT_VALID  in  1  ALU result valid.
- FIFO_FULL  in  1  TX FIFO full.
- WrEn  out  1  RF write strobe.
- RdEn  out  1  RF read strobe.
- address  out  ADDR_WIDTH  RF address.
- WrData  out  DATA_WIDTH  RF write data.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  4  ALU function.
- CLK_EN  out  1  ALU clock-gate enable.
- clk_div_en  out  1  clock divider enable.
- TX_P_DATA  out  DATA_WIDTH  word to TX FIFO.
- TX_D_VLD  out  1  FIFO write strobe.
- CMD_ERR  out  1  one-cycle error pulse.

Function
REQ-003 All outputs SHALL be registered; a strobe output is high for exactly one cycle per event.
REQ-004 Frames SHALL be decoded from the low 8 bits of each word, upper bits zero:
- 0xAA addr data: RF write.
- 0xBB addr: RF read.
- 0xCC A B fun: write A to RF address 0, write B to RF address 1, then run the ALU.
- 0xDD fun: run the ALU on the stored operands.
REQ-005 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD, TX_ERR.
REQ-006 In IDLE, a word that is not a command code SHALL pulse CMD_ERR and go to TX_ERR, which sends ERR_CODE 0xEE (zero-extended).
REQ-007 An address word with any bit set at or above ADDR_WIDTH SHALL pulse CMD_ERR and go to TX_ERR.
REQ-008 WrEn, address and WrData SHALL be valid the cycle after the RX_D_VLD of the data word (WR_DATA, OPA, OPB); the FSM then returns to IDLE, or advances for OPA/OPB.
REQ-009 RdEn SHALL pulse the cycle after the address word. RD_WAIT latches Rd_Data on Rd_Data_Valid, then goes to TX_RD.
REQ-010 On the fun word, ALU_FUN SHALL take word[3:0] and ALU_EN pulse the next cycle.
REQ-011 CLK_EN SHALL be high from the ALU_EN cycle until the cycle after OUT_VALID; the FSM latches ALU_OUT on OUT_VALID.
REQ-012 After ALU_WAIT, TX_LO SHALL send ALU_OUT[DATA_WIDTH-1:0], then TX_HI sends the upper half, then the FSM returns to IDLE.
REQ-013 TX_D_VLD SHALL assert only while FIFO_FULL=0; while FIFO_FULL=1 the TX state and TX_P_DATA hold.
REQ-014 A timeout counter SHALL count in every non-IDLE, non-TX state and clear on RX_D_VLD, Rd_Data_Valid, OUT_VALID or a state change.
REQ-015 When the count reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE with CMD_ERR pulsed and CLK_EN low; no partial RF write occurs.
REQ-016 An RX_D_VLD during any TX_* state SHALL drop the word and pulse CMD_ERR.
REQ-017 If OUT_VALID or Rd_Data_Valid coincides with a timeout, the valid SHALL win.
REQ-018 clk_div_en SHALL be 1 from the first cycle after reset release.

Reset
REQ-019 RST high SHALL asynchronously force IDLE, all outputs to 0, the counter to 0 and all latched data to 0, including mid-frame and mid-TX.
REQ-020 After RST deasserts, a new frame SHALL be accepted on the first RX_D_VLD.

Structure
REQ-021 Package sys_ctrl_pkg SHALL hold the command codes (0xAA, 0xBB, 0xCC, 0xDD), ERR_CODE 0xEE, the state enum and the ALU operand addresses 0 and 1.
REQ-022 The timeout counter SHALL be sub-module sys_ctrl_timer (inputs: clear, run; output: expired), width $clog2(TIMEOUT_CYCLES).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- AA,05,3C -> WrEn one cycle, address=5, WrData=0x3C, no TX.
- BB,05 with RF returning 0x3C after 3 cycles -> RdEn one cycle; TX_P_DATA=0x3C once.
- CC,07,03,00 (add), ALU_OUT=0x000A -> writes 0x07@0 and 0x03@1; TX 0x0A then 0x00; CLK_EN low after.
- 0x55 in IDLE; later AA,1F -> each pulses CMD_ERR and TXes 0xEE.
- AA then silence for TIMEOUT_CYCLES -> CMD_ERR, IDLE, WrEn never asserted.
- FIFO_FULL=1 for 10 cycles during TX_LO -> no TX_D_VLD, data stable; word sent the cycle after FIFO_FULL drops.
- RST pulse during ALU_WAIT -> all outputs 0 immediately.
